sev_seg_scheduler: RTL and testbench
====================================

Name: sev_seg_scheduler

Overview:
Time-multiplex scheduler for the dual seven-segment display. It divides the system clock into fixed-length digit phases and alternates the two digit-select lines, with a guaranteed blanking interval between them to prevent ghosting. It captures the matching 4-bit switch operand at the start of each digit phase and presents it to the shared hex-to-segment decoder. It sits between the switch inputs and the decoder/anode drivers.

Parameters:
DIGIT_CYCLES, 100000, clk cycles each digit is lit; must be >= 1
BLANK_CYCLES, 2000, clk cycles with both digits off between digits; must be >= 1
CNT_W, $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)+1), phase counter width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  scheduler enable; 0 forces the display dark
onboard_sw  input  4  operand for digit 1
bboard_sw  input  4  operand for digit 2
seg1sel  output  1  digit 1 select, active-high
seg2sel  output  1  digit 2 select, active-high
sw  output  4  operand to the shared decoder
phase_tick  output  1  one-cycle pulse on the first cycle of each digit phase

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset. No logic on negedge clk.
- States: S_BLANK1 -> S_DIG1 -> S_BLANK2 -> S_DIG2 -> S_BLANK1. Reset state is S_BLANK1.
- Phase counter cnt runs 0..N-1, where N = BLANK_CYCLES in the blank states and DIGIT_CYCLES in the digit states. When cnt == N-1, the state advances and cnt returns to 0. Otherwise cnt increments by 1.
- Each blank phase lasts exactly BLANK_CYCLES cycles and each digit phase exactly DIGIT_CYCLES cycles. The full frame is 2*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- All outputs are registered:
  - seg1sel = 1 iff state == S_DIG1.
  - seg2sel = 1 iff state == S_DIG2.
  - phase_tick = 1 in the cycle a DIG state is entered.
- sw loading:
  - On the edge that enters S_DIG1, sw loads onboard_sw.
  - On the edge that enters S_DIG2, sw loads bboard_sw.
  - sw holds otherwise, so it is stable for the whole digit phase. Input changes mid-phase do not appear until that digit's next phase.
- Invariants:
  - seg1sel and seg2sel are never both 1.
  - Between any deassertion of one select and assertion of the other, there are >= BLANK_CYCLES cycles with both at 0.
- Reset values: state = S_BLANK1, cnt = 0, seg1sel = 0, seg2sel = 0, sw = 4'h0, phase_tick = 0.
- Reset asserted mid-phase: at the next edge, all registers take their reset values regardless of state or cnt.
- en = 0:
  - At the next edge, state = S_BLANK1 and cnt = 0; selects and phase_tick go to 0; sw holds its value.
  - While en stays 0, the block remains there.
- en returning to 1: the sequence restarts with a full BLANK1 phase. The first digit lit is always digit 1.
- reset has priority over en.
- Boundary cases:
  - DIGIT_CYCLES = 1: each digit is lit for exactly one cycle and phase_tick coincides with it.
  - The counter never wraps past N-1. There are no illegal states; an unreachable encoding returns to S_BLANK1.

Decomposition:
- Package sev_seg_pkg:
  - typedef enum logic [1:0] state_t {S_BLANK1, S_DIG1, S_BLANK2, S_DIG2}.
  - Localparam DIGIT_W = 4.
  - Function phase_len(state_t), returning the terminal count per state.
- One sub-module, phase_timer: a loadable down/up counter with a terminal-count output and a sync clear (clk, reset, clr, len, done).
- The FSM and the output registers stay in sev_seg_scheduler.

Test Plan:
All scenarios use DIGIT_CYCLES=4 and BLANK_CYCLES=2 unless stated otherwise.
1. Reset: hold reset 3 cycles with inputs 4'hA/4'h5, then release -> seg1sel=seg2sel=0 and sw=0 during reset. After release: 2 dark cycles, seg1sel=1 for 4 cycles with sw=4'hA, 2 dark, seg2sel=1 for 4 cycles with sw=4'h5. Frame period = 12.
2. Mid-phase input change: change onboard_sw 4'h3->4'h7 in cycle 2 of DIG1 -> sw stays 4'h3 until the next DIG1 entry, then 4'h7. phase_tick pulses exactly once per digit phase (2 per 12 cycles).
3. Mutual exclusion: 1000 cycles with random inputs -> never seg1sel&seg2sel; every select transition separated by >= 2 all-dark cycles.
4. Enable: deassert en during DIG2 cycle 1 -> both selects 0 at the next edge, sw unchanged. Re-assert after 5 cycles -> exactly 2 dark cycles, then DIG1.
5. Sync reset mid-operation: assert reset for 1 cycle during DIG1 cycle 3 -> all outputs at reset values on the next edge; sequence restarts from BLANK1. Asynchronous pulses of reset between edges have no effect.
6. Degenerate timing (DIGIT_CYCLES=1, BLANK_CYCLES=1) -> pattern dark, seg1, dark, seg2 repeating with period 4. phase_tick is high in every cycle a select is high.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the dual seven-segment display scheduler.
//   state_t   : scheduler phase (blank/digit interleave)
//   DIGIT_W   : width of one hex operand
//   phase_len : terminal count (length - 1) of the phase for a given state
package sev_seg_pkg;

  typedef enum logic [1:0] {
    S_BLANK1 = 2'd0,
    S_DIG1   = 2'd1,
    S_BLANK2 = 2'd2,
    S_DIG2   = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W = 4;

  // Phase lengths depend on module parameters, so they are passed in.
  function automatic int unsigned phase_len(input state_t s,
                                            input int unsigned digit_cycles,
                                            input int unsigned blank_cycles);
    case (s)
      S_DIG1, S_DIG2: return digit_cycles - 1;
      default:        return blank_cycles - 1;
    endcase
  endfunction

endpackage

// File: rtl/sev_seg_scheduler_phase_timer.sv
// Phase timer: counts 0..len and flags the terminal count.
//   clk   : system clock
//   reset : synchronous active-high reset, counter to 0
//   clr   : synchronous clear, counter to 0
//   len   : terminal count for the current phase (phase length - 1)
//   done  : high while the counter sits on its terminal count
module phase_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == len);

  // Wrapping on done keeps the counter from ever passing the terminal count,
  // even when len changes on a phase boundary.
  always_ff @(posedge clk) begin
    if (reset || clr || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sev_seg_scheduler.sv
// Time-multiplex scheduler for a dual seven-segment display.
// Sequence BLANK1 -> DIG1 -> BLANK2 -> DIG2, with a blank interval between
// the two digits; the operand for each digit is captured on phase entry.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   en         : enable; low forces the display dark and restarts at BLANK1
//   onboard_sw : operand for digit 1
//   bboard_sw  : operand for digit 2
//   seg1sel    : digit 1 select (registered, active-high)
//   seg2sel    : digit 2 select (registered, active-high)
//   sw         : operand to the shared hex decoder (registered)
//   phase_tick : one-cycle pulse on the first cycle of each digit phase
module sev_seg_scheduler
  import sev_seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [DIGIT_W-1:0] onboard_sw,
  input  logic [DIGIT_W-1:0] bboard_sw,
  output logic               seg1sel,
  output logic               seg2sel,
  output logic [DIGIT_W-1:0] sw,
  output logic               phase_tick
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES
                                                                  : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   len;
  logic               done;
  logic               clr;
  logic               enter_dig1, enter_dig2;
  logic [DIGIT_W-1:0] sw_next;

  assign len = CNT_W'(phase_len(state, DIGIT_CYCLES, BLANK_CYCLES));
  assign clr = ~en;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .len   (len),
    .done  (done)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_BLANK1: if (done) state_next = S_DIG1;
      S_DIG1:   if (done) state_next = S_BLANK2;
      S_BLANK2: if (done) state_next = S_DIG2;
      S_DIG2:   if (done) state_next = S_BLANK1;
      default:  state_next = S_BLANK1;
    endcase
    if (!en) begin
      state_next = S_BLANK1;
    end

    enter_dig1 = (state_next == S_DIG1) && (state != S_DIG1);
    enter_dig2 = (state_next == S_DIG2) && (state != S_DIG2);

    sw_next = sw;
    if (enter_dig1) begin
      sw_next = onboard_sw;
    end else if (enter_dig2) begin
      sw_next = bboard_sw;
    end
  end

  // Outputs are registered from state_next so they line up with the state
  // register in the same cycle rather than lagging it by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BLANK1;
      seg1sel    <= 1'b0;
      seg2sel    <= 1'b0;
      sw         <= '0;
      phase_tick <= 1'b0;
    end else begin
      state      <= state_next;
      seg1sel    <= (state_next == S_DIG1);
      seg2sel    <= (state_next == S_DIG2);
      sw         <= sw_next;
      phase_tick <= enter_dig1 | enter_dig2;
    end
  end

endmodule

// File: tb/tb_sev_seg_scheduler.sv
module tb_sev_seg_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: DIGIT_CYCLES=4, BLANK_CYCLES=2
  logic       reset, en;
  logic [3:0] ob, bb;
  logic       s1, s2, tick;
  logic [3:0] sw;

  // degenerate instance: DIGIT_CYCLES=1, BLANK_CYCLES=1
  logic       reset_d, en_d;
  logic [3:0] ob_d, bb_d;
  logic       s1_d, s2_d, tick_d;
  logic [3:0] sw_d;

  sev_seg_scheduler #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .onboard_sw (ob),
    .bboard_sw  (bb),
    .seg1sel    (s1),
    .seg2sel    (s2),
    .sw         (sw),
    .phase_tick (tick)
  );

  sev_seg_scheduler #(.DIGIT_CYCLES(1), .BLANK_CYCLES(1)) u_deg (
    .clk        (clk),
    .reset      (reset_d),
    .en         (en_d),
    .onboard_sw (ob_d),
    .bboard_sw  (bb_d),
    .seg1sel    (s1_d),
    .seg2sel    (s2_d),
    .sw         (sw_d),
    .phase_tick (tick_d)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] ob;
    logic [3:0] bb;
    logic       s1;
    logic       s2;
    logic [3:0] sw;
    logic       tick;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add_n(input int n, input logic r, input logic e,
                       input logic [3:0] o, input logic [3:0] b,
                       input logic e1, input logic e2, input logic [3:0] esw,
                       input logic tick_first);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst  = r;
      v.en   = e;
      v.ob   = o;
      v.bb   = b;
      v.s1   = e1;
      v.s2   = e2;
      v.sw   = esw;
      v.tick = tick_first && (i == 0);
      vecs.push_back(v);
    end
  endtask

  // packed as {seg1sel, seg2sel, sw, phase_tick}
  task automatic check(input string name, input int idx,
                       input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got {s1,s2,sw,tick}=%b_%b_%h_%b expected %b_%b_%h_%b",
               name, idx, got[6], got[5], got[4:1], got[0],
               exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic       prev_any, seen_lit;
    logic [1:0] last_lit;
    int         dark_run;
    logic [6:0] exp;

    reset = 1'b1; en = 1'b1; ob = 4'hA; bb = 4'h5;
    reset_d = 1'b1; en_d = 1'b1; ob_d = 4'hC; bb_d = 4'h3;

    // reset, first frame
    add_n(3, 1, 1, 4'hA, 4'h5, 0, 0, 4'h0, 0);
    add_n(1, 0, 1, 4'hA, 4'h5, 0, 0, 4'h0, 0);
    add_n(4, 0, 1, 4'hA, 4'h5, 1, 0, 4'hA, 1);
    add_n(2, 0, 1, 4'hA, 4'h5, 0, 0, 4'hA, 0);
    add_n(4, 0, 1, 4'hA, 4'h5, 0, 1, 4'h5, 1);
    // mid-phase operand change
    add_n(2, 0, 1, 4'h3, 4'h5, 0, 0, 4'h5, 0);
    add_n(1, 0, 1, 4'h3, 4'h5, 1, 0, 4'h3, 1);
    add_n(3, 0, 1, 4'h7, 4'h5, 1, 0, 4'h3, 0);
    add_n(2, 0, 1, 4'h7, 4'h5, 0, 0, 4'h3, 0);
    add_n(4, 0, 1, 4'h7, 4'h5, 0, 1, 4'h5, 1);
    add_n(2, 0, 1, 4'h7, 4'h5, 0, 0, 4'h5, 0);
    add_n(4, 0, 1, 4'h7, 4'h5, 1, 0, 4'h7, 1);
    add_n(2, 0, 1, 4'h7, 4'h5, 0, 0, 4'h7, 0);
    // enable dropped after DIG2 cycle 1, restored 5 cycles later
    add_n(1, 0, 1, 4'h7, 4'h5, 0, 1, 4'h5, 1);
    add_n(5, 0, 0, 4'h7, 4'h5, 0, 0, 4'h5, 0);
    add_n(1, 0, 1, 4'h7, 4'h5, 0, 0, 4'h5, 0);
    add_n(2, 0, 1, 4'h7, 4'h5, 1, 0, 4'h7, 1);
    // reset pulse during DIG1 cycle 3
    add_n(1, 1, 1, 4'h7, 4'h5, 0, 0, 4'h0, 0);
    add_n(1, 0, 1, 4'h7, 4'h5, 0, 0, 4'h0, 0);
    add_n(4, 0, 1, 4'h7, 4'h5, 1, 0, 4'h7, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      en    = vecs[i].en;
      ob    = vecs[i].ob;
      bb    = vecs[i].bb;
      cyc();
      check("vec", i, {s1, s2, sw, tick},
            {vecs[i].s1, vecs[i].s2, vecs[i].sw, vecs[i].tick});
    end

    // reset glitch that does not straddle an edge is ignored (now DIG1 cnt 3)
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("glitch", 0, {s1, s2, sw, tick}, {1'b0, 1'b0, 4'h7, 1'b0});
    cyc();
    check("glitch", 1, {s1, s2, sw, tick}, {1'b0, 1'b0, 4'h7, 1'b0});
    cyc();
    check("glitch", 2, {s1, s2, sw, tick}, {1'b0, 1'b1, 4'h5, 1'b1});

    // random operands: exclusion, blank gap, alternation, tick on entry
    prev_any = 1'b1; seen_lit = 1'b1; last_lit = 2'd2; dark_run = 0;
    for (int c = 0; c < 1000; c++) begin
      ob = 4'($urandom);
      bb = 4'($urandom);
      cyc();
      total++;
      if (s1 && s2) begin
        bad++;
        $display("FAIL excl[%0d] got s1=%b s2=%b expected not both", c, s1, s2);
      end
      total++;
      if (tick !== ((s1 || s2) && !prev_any)) begin
        bad++;
        $display("FAIL tick[%0d] got %b expected %b", c, tick, (s1 || s2) && !prev_any);
      end
      if ((s1 || s2) && !prev_any) begin
        total++;
        if (seen_lit && (dark_run < 2 || (s1 && last_lit == 2'd1) ||
                         (s2 && last_lit == 2'd2))) begin
          bad++;
          $display("FAIL gap[%0d] got dark=%0d last=%0d expected dark>=2 alternating",
                   c, dark_run, last_lit);
        end
        seen_lit = 1'b1;
        last_lit = s1 ? 2'd1 : 2'd2;
      end
      dark_run = (s1 || s2) ? 0 : dark_run + 1;
      prev_any = s1 || s2;
    end

    // degenerate timing: dark, seg1, dark, seg2 with period 4
    cyc();
    reset_d = 1'b0;
    check("deg", 0, {s1_d, s2_d, sw_d, tick_d}, 7'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      case (k % 4)
        1:       exp = {1'b1, 1'b0, 4'hC, 1'b1};
        2:       exp = {1'b0, 1'b0, 4'hC, 1'b0};
        3:       exp = {1'b0, 1'b1, 4'h3, 1'b1};
        default: exp = {1'b0, 1'b0, 4'h3, 1'b0};
      endcase
      check("deg", k, {s1_d, s2_d, sw_d, tick_d}, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
